// File: rtl/mesm6_dbus_debug_master_if.sv
`default_nettype none
// ============================================================================
// Module   : mesm6_dbus_debug_master_if
// Brief    : Serial byte streams, dbus request/response and status of the debug master.
// Revision : 1.0
// ============================================================================
interface mesm6_dbus_debug_master_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_rd;
    logic        bus_wr;
    logic [14:0] bus_addr;
    logic [47:0] bus_wdata;
    logic [47:0] bus_rdata;
    logic        bus_done;
    logic        busy;
    logic        overrun;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_rdata, bus_done,
        output tx_data, tx_valid, bus_rd, bus_wr, bus_addr, bus_wdata, busy, overrun
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_rdata, bus_done,
        input  tx_data, tx_valid, bus_rd, bus_wr, bus_addr, bus_wdata, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/mesm6_dbus_debug_master.sv
`default_nettype none
// ============================================================================
// Module   : mesm6_dbus_debug_master
// Brief    : Byte-serial command interpreter issuing single dbus reads/writes.
// Revision : 1.0
// ============================================================================
module mesm6_dbus_debug_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    mesm6_dbus_debug_master_if.master    dbg
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ADDR_HI = 3'd1;
    localparam logic [2:0] c_ST_ADDR_LO = 3'd2;
    localparam logic [2:0] c_ST_DATA    = 3'd3;
    localparam logic [2:0] c_ST_BUS     = 3'd4;
    localparam logic [2:0] c_ST_RESP    = 3'd5;

    localparam logic [7:0] c_OP_RD   = 8'h52;
    localparam logic [7:0] c_OP_WR   = 8'h57;
    localparam logic [7:0] c_RSP_RD  = 8'h72;
    localparam logic [7:0] c_RSP_WR  = 8'h77;
    localparam logic [7:0] c_RSP_TMO = 8'h54;
    localparam logic [7:0] c_RSP_BAD = 8'h3F;

    logic [2:0]       r_state;
    logic             r_is_wr;
    logic [2:0]       r_dcnt;
    logic [TMO_W-1:0] r_tmo;
    logic [55:0]      r_resp;
    logic [2:0]       r_rcnt;
    logic             r_tx_valid;
    logic             r_bus_rd;
    logic             r_bus_wr;
    logic [14:0]      r_addr;
    logic [47:0]      r_wdata;
    logic             r_overrun;

    // Response bytes leave MSB first from the top of the shift buffer.
    assign dbg.tx_data   = r_resp[55:48];
    assign dbg.tx_valid  = r_tx_valid;
    assign dbg.bus_rd    = r_bus_rd;
    assign dbg.bus_wr    = r_bus_wr;
    assign dbg.bus_addr  = r_addr;
    assign dbg.bus_wdata = r_wdata;
    assign dbg.busy      = (r_state != c_ST_IDLE);
    assign dbg.overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_is_wr    <= 1'b0;
            r_dcnt     <= 3'd0;
            r_tmo      <= '0;
            r_resp     <= 56'h0;
            r_rcnt     <= 3'd0;
            r_tx_valid <= 1'b0;
            r_bus_rd   <= 1'b0;
            r_bus_wr   <= 1'b0;
            r_addr     <= 15'h0;
            r_wdata    <= 48'h0;
            r_overrun  <= 1'b0;
        end else begin
            if (dbg.rx_valid && (r_state == c_ST_BUS || r_state == c_ST_RESP))
                r_overrun <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (dbg.rx_valid) begin
                        if (dbg.rx_data == c_OP_RD) begin
                            r_is_wr <= 1'b0;
                            r_state <= c_ST_ADDR_HI;
                        end else if (dbg.rx_data == c_OP_WR) begin
                            r_is_wr <= 1'b1;
                            r_state <= c_ST_ADDR_HI;
                        end else begin
                            r_resp     <= {c_RSP_BAD, 48'h0};
                            r_rcnt     <= 3'd1;
                            r_tx_valid <= 1'b1;
                            r_state    <= c_ST_RESP;
                        end
                    end
                end
                c_ST_ADDR_HI: begin
                    if (dbg.rx_valid) begin
                        r_addr[14:8] <= dbg.rx_data[6:0];
                        r_state      <= c_ST_ADDR_LO;
                    end
                end
                c_ST_ADDR_LO: begin
                    if (dbg.rx_valid) begin
                        r_addr[7:0] <= dbg.rx_data;
                        r_tmo       <= '0;
                        r_dcnt      <= 3'd0;
                        if (r_is_wr) begin
                            r_state <= c_ST_DATA;
                        end else begin
                            r_bus_rd <= 1'b1;
                            r_state  <= c_ST_BUS;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (dbg.rx_valid) begin
                        r_wdata <= {r_wdata[39:0], dbg.rx_data};
                        r_dcnt  <= r_dcnt + 3'd1;
                        if (r_dcnt == 3'd5) begin
                            r_bus_wr <= 1'b1;
                            r_state  <= c_ST_BUS;
                        end
                    end
                end
                c_ST_BUS: begin
                    // Completion takes priority over an expiring timeout.
                    if (dbg.bus_done) begin
                        r_bus_rd   <= 1'b0;
                        r_bus_wr   <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_state    <= c_ST_RESP;
                        if (r_is_wr) begin
                            r_resp <= {c_RSP_WR, 48'h0};
                            r_rcnt <= 3'd1;
                        end else begin
                            r_resp <= {c_RSP_RD, dbg.bus_rdata};
                            r_rcnt <= 3'd7;
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_bus_rd   <= 1'b0;
                        r_bus_wr   <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_resp     <= {c_RSP_TMO, 48'h0};
                        r_rcnt     <= 3'd1;
                        r_state    <= c_ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    if (r_tx_valid && dbg.tx_ready) begin
                        r_resp <= {r_resp[47:0], 8'h00};
                        r_rcnt <= r_rcnt - 3'd1;
                        if (r_rcnt == 3'd1) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mesm6_dbus_debug_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesm6_dbus_debug_master
// Brief    : Scoreboard bench: directed commands, queued expected bus/tx traffic.
// Revision : 1.0
// ============================================================================
module tb_mesm6_dbus_debug_master;
    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [47:0] wdata;
        int          len;
    } bus_t;

    logic clk;
    logic reset;
    mesm6_dbus_debug_master_if u_if ();

    mesm6_dbus_debug_master #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .dbg   (u_if)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  txq[$];
    bus_t        busq[$];
    bus_t        cur;
    int          n_req = 0;
    int          req_len = 0;
    logic        prev_req = 1'b0;
    logic        skip_lat = 1'b0;
    int          done_delay = 0;
    logic [47:0] rd_value = 48'h0;
    int          resp_cnt = 0;
    int          ready_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_read(input logic [47:0] d);
        txq.push_back(8'h72);
        for (int i = 5; i >= 0; i--) txq.push_back(d[i*8 +: 8]);
    endtask

    task automatic exp_bus(input logic wr, input logic [14:0] a, input logic [47:0] d, input int len);
        bus_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.len = len;
        busq.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(posedge clk); #1;
        u_if.rx_valid = 1'b0;
    endtask

    task automatic chk_req_latency();
        chk("req_latency", u_if.bus_rd | u_if.bus_wr, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((u_if.busy || u_if.tx_valid || txq.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_within_budget", n < budget, 1'b1);
    endtask

    task automatic chk_all_zero();
        chk("rst_tx_valid", u_if.tx_valid, 1'b0);
        chk("rst_bus_rd", u_if.bus_rd, 1'b0);
        chk("rst_bus_wr", u_if.bus_wr, 1'b0);
        chk("rst_busy", u_if.busy, 1'b0);
        chk("rst_overrun", u_if.overrun, 1'b0);
        chk("rst_tx_data", u_if.tx_data, 8'h00);
        chk("rst_bus_addr", u_if.bus_addr, 15'h0);
        chk("rst_bus_wdata", u_if.bus_wdata, 48'h0);
    endtask

    // Bus responder: done in the done_delay-th request cycle (0 = never).
    initial begin
        u_if.bus_done  = 1'b0;
        u_if.bus_rdata = 48'h0;
        forever begin
            @(posedge clk); #1;
            if (u_if.bus_rd || u_if.bus_wr) begin
                resp_cnt++;
                if (done_delay != 0 && resp_cnt == done_delay) begin
                    u_if.bus_done  = 1'b1;
                    u_if.bus_rdata = rd_value;
                end else begin
                    u_if.bus_done = 1'b0;
                end
            end else begin
                resp_cnt      = 0;
                u_if.bus_done = 1'b0;
            end
        end
    end

    initial begin
        u_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       u_if.tx_ready = 1'b1;
                1:       u_if.tx_ready = ~u_if.tx_ready;
                default: u_if.tx_ready = 1'b0;
            endcase
        end
    end

    // Transmit monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (u_if.tx_valid && u_if.tx_ready) begin
                if (txq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL tx_unexpected: got %02h expected none", u_if.tx_data);
                end else begin
                    chk("tx_byte", u_if.tx_data, txq.pop_front());
                end
            end
        end
    end

    // Bus monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) chk("rd_wr_exclusive", u_if.bus_rd & u_if.bus_wr, 1'b0);
            if ((u_if.bus_rd || u_if.bus_wr) && !prev_req) begin
                n_req++;
                req_len = 1;
                if (busq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bus_unexpected: got addr %0h expected none", u_if.bus_addr);
                    cur.wr = u_if.bus_wr; cur.addr = u_if.bus_addr;
                    cur.wdata = u_if.bus_wdata; cur.len = 0;
                end else begin
                    cur = busq.pop_front();
                    chk("bus_is_write", u_if.bus_wr, cur.wr);
                    chk("bus_addr", u_if.bus_addr, cur.addr);
                    if (cur.wr) chk("bus_wdata", u_if.bus_wdata, cur.wdata);
                    cur.wdata = u_if.bus_wdata;
                end
            end else if ((u_if.bus_rd || u_if.bus_wr) && prev_req) begin
                req_len++;
                chk("bus_addr_stable", u_if.bus_addr, cur.addr);
                chk("bus_wdata_stable", u_if.bus_wdata, cur.wdata);
            end else if (prev_req) begin
                if (cur.len != 0) chk("bus_req_length", req_len, cur.len);
                if (!skip_lat) chk("done_to_tx_valid", u_if.tx_valid, 1'b1);
            end
            prev_req = u_if.bus_rd | u_if.bus_wr;
        end
    end

    initial begin
        int reqs_before;
        reset         = 1'b0;
        u_if.rx_data  = 8'h00;
        u_if.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero();
        reset = 1'b1;
        @(posedge clk); #1;

        // Write with done in the third request cycle.
        done_delay = 3;
        exp_bus(1'b1, 15'h0123, 48'hDEADBEEF1234, 3);
        txq.push_back(8'h77);
        send(8'h57); send(8'h01); send(8'h23);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h12); send(8'h34);
        chk_req_latency();
        wait_idle(200);

        // Read with address bit 15 ignored and a stuttering transmitter.
        ready_mode = 1;
        done_delay = 2;
        rd_value   = 48'h0123456789AB;
        exp_bus(1'b0, 15'h0100, 48'h0, 2);
        exp_read(48'h0123456789AB);
        send(8'h52); send(8'h81); send(8'h00);
        chk_req_latency();
        wait_idle(200);
        ready_mode = 0;
        @(posedge clk); #1;

        // Timeout: request held exactly 16 cycles.
        done_delay = 0;
        exp_bus(1'b0, 15'h0005, 48'h0, 16);
        txq.push_back(8'h54);
        send(8'h52); send(8'h00); send(8'h05);
        chk_req_latency();
        wait_idle(200);

        // Unknown opcode, then a normal read.
        reqs_before = n_req;
        txq.push_back(8'h3F);
        send(8'h00);
        wait_idle(100);
        chk("no_bus_on_bad_op", n_req, reqs_before);
        done_delay = 1;
        rd_value   = 48'hA5A50000FFFF;
        exp_bus(1'b0, 15'h0000, 48'h0, 1);
        exp_read(48'hA5A50000FFFF);
        send(8'h52); send(8'h00); send(8'h00);
        wait_idle(200);
        chk("overrun_clear", u_if.overrun, 1'b0);

        // Overrun: a stray byte during BUS is dropped.
        done_delay = 6;
        rd_value   = 48'hCAFEF00D1357;
        exp_bus(1'b0, 15'h1234, 48'h0, 6);
        exp_read(48'hCAFEF00D1357);
        send(8'h52); send(8'h12); send(8'h34);
        repeat (2) @(posedge clk); #1;
        send(8'h57);
        wait_idle(200);
        chk("overrun_set", u_if.overrun, 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("no_cmd_from_overrun", u_if.busy, 1'b0);

        // Reset mid-BUS.
        done_delay = 0;
        exp_bus(1'b0, 15'h0007, 48'h0, 0);
        send(8'h52); send(8'h00); send(8'h07);
        repeat (3) @(posedge clk); #1;
        skip_lat = 1'b1;
        reset    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero();
        reset = 1'b1;
        @(posedge clk); #1;
        skip_lat = 1'b0;

        // Reset mid-RESP with the transmitter stalled.
        ready_mode = 2;
        @(posedge clk); #1;
        send(8'h00);
        repeat (3) @(posedge clk); #1;
        chk("tx_valid_held", u_if.tx_valid, 1'b1);
        chk("tx_data_held", u_if.tx_data, 8'h3F);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero();
        reset      = 1'b1;
        ready_mode = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Command after reset.
        done_delay = 2;
        exp_bus(1'b1, 15'h7FFF, 48'h001122334455, 2);
        txq.push_back(8'h77);
        send(8'h57); send(8'hFF); send(8'hFF);
        send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        chk_req_latency();
        wait_idle(200);

        repeat (4) @(posedge clk); #1;
        chk("tx_queue_drained", txq.size(), 0);
        chk("bus_queue_drained", busq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
